// File: rtl/pifo_pkg.sv
// pifo_pkg: shared widths and element type for the PIFO front-end.
package pifo_pkg;
  localparam int RANK_W = 32;
  localparam int VALUE_W = 32;
  typedef struct packed {
    logic [RANK_W-1:0]  rank;
    logic [VALUE_W-1:0] value;
  } pifo_elem_t;
endpackage

// File: rtl/pifo_push_pop_ctrl_rr_pick.sv
// rr_pick: rotated find-first-set from a start pointer with an exclude mask.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [$clog2(N)-1:0] start,
  input  logic [N-1:0]         valid,
  input  logic [N-1:0]         excl,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [2*N-1:0] dbl;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  always_comb begin
    dbl = {valid & ~excl, valid & ~excl} >> start;
    found = 1'b0;
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        found = 1'b1;
        off = IW'(k);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
  end
endmodule

// File: rtl/pifo_push_pop_ctrl.sv
// pifo_push_pop_ctrl: round-robin two-push arbitration, occupancy credit and
// pop-to-stream conversion through a 2-entry skid buffer for the FlowScheduler PIFO.
module pifo_push_pop_ctrl
  import pifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SIZE  = 10,
  parameter int FLOWS = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][RANK_W-1:0]    req_rank,
  input  logic [N_REQ-1:0][VALUE_W-1:0]   req_value,
  input  logic [N_REQ-1:0][FLOWS-1:0]     req_flow,
  output logic                            push_1,
  output logic [RANK_W-1:0]               push_rank_1,
  output logic [VALUE_W-1:0]              push_value_1,
  output logic [FLOWS-1:0]                push_flow_1,
  output logic                            push_2,
  output logic [RANK_W-1:0]               push_rank_2,
  output logic [VALUE_W-1:0]              push_value_2,
  output logic [FLOWS-1:0]                push_flow_2,
  output logic                            pop,
  input  logic [VALUE_W-1:0]              pop_value,
  input  logic [FLOWS-1:0]                pop_flow,
  input  logic                            pop_valid,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [VALUE_W-1:0]              out_value,
  output logic [FLOWS-1:0]                out_flow,
  output logic [$clog2(SIZE+1)-1:0]       occupancy
);
  localparam int CW = $clog2(SIZE + 1);
  localparam int IW = $clog2(N_REQ);
  logic [CW-1:0]      count_q, count_d, free;
  logic [IW-1:0]      rr_q, rr_d, g0_idx, g1_idx;
  logic               inflight_q, inflight_d, head_q, head_d, g0_found, g1_found, deq, enq, wr;
  logic [1:0]         skid_cnt_q, skid_cnt_d;
  logic [2:0]         pending;
  logic [N_REQ-1:0]   g0_mask, g1_mask;
  logic [VALUE_W-1:0] sv_q [2], sv_d [2];
  logic [FLOWS-1:0]   sf_q [2], sf_d [2];
  pifo_elem_t         e1, e2;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(N_REQ)) u_g0 (.start(rr_q), .valid(req_valid), .excl('0), .found(g0_found), .idx(g0_idx));
  rr_pick #(.N(N_REQ)) u_g1 (.start(rr_q), .valid(req_valid), .excl(g0_mask), .found(g1_found), .idx(g1_idx));

  always_comb begin
    g0_mask = N_REQ'(1) << g0_idx;
    g1_mask = N_REQ'(1) << g1_idx;
    free = CW'(SIZE) - count_q;
    push_1 = !rst && g0_found && free >= CW'(1);
    push_2 = push_1 && g1_found && free >= CW'(2);
    req_ready = (push_1 ? g0_mask : '0) | (push_2 ? g1_mask : '0);
    e1 = {req_rank[g0_idx], req_value[g0_idx]};
    e2 = {req_rank[g1_idx], req_value[g1_idx]};
    push_rank_1 = e1.rank;
    push_value_1 = e1.value;
    push_flow_1 = req_flow[g0_idx];
    push_rank_2 = e2.rank;
    push_value_2 = e2.value;
    push_flow_2 = req_flow[g1_idx];
    out_valid = skid_cnt_q != 2'd0;
    out_value = sv_q[head_q];
    out_flow = sf_q[head_q];
    occupancy = count_q;
    deq = out_valid && out_ready;
    // buffered plus in-flight results after this cycle's dequeue must leave room for one more
    pending = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(deq);
    pop = !rst && count_q != '0 && pending < 3'd2;
    count_d = count_q + CW'(push_1) + CW'(push_2) - CW'(pop);
    rr_d = push_2 ? nxt(g1_idx) : push_1 ? nxt(g0_idx) : rr_q;
    inflight_d = pop;
    enq = inflight_q && pop_valid;
    wr = head_q ^ skid_cnt_q[0];
    sv_d = sv_q;
    sf_d = sf_q;
    if (enq) begin
      sv_d[wr] = pop_value;
      sf_d[wr] = pop_flow;
    end
    head_d = head_q ^ deq;
    skid_cnt_d = skid_cnt_q + 2'(enq) - 2'(deq);
  end

  always_ff @(posedge clk) begin
    sv_q <= sv_d;
    sf_q <= sf_d;
    if (rst) begin
      count_q <= '0;
      rr_q <= '0;
      inflight_q <= 1'b0;
      head_q <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      count_q <= count_d;
      rr_q <= rr_d;
      inflight_q <= inflight_d;
      head_q <= head_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  a_pop_result: assert property (@(posedge clk) disable iff (rst) inflight_q |-> pop_valid);
endmodule

// File: tb/tb_pifo_push_pop_ctrl.sv
// tb_pifo_push_pop_ctrl: directed bench with a queue-based PIFO environment and a
// queue-level expectation model checked every cycle.
module tb_pifo_push_pop_ctrl;
  localparam int N = 4, SIZE = 10, FLOWS = 10, CW = $clog2(SIZE + 1);
  typedef struct packed {
    logic [31:0]      rank;
    logic [31:0]      value;
    logic [FLOWS-1:0] flow;
  } el_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N-1:0][31:0] req_rank = '0, req_value = '0;
  logic [N-1:0][FLOWS-1:0] req_flow = '0;
  logic push_1, push_2, pop, out_valid, out_ready = 1'b0;
  logic pop_valid = 1'b0;
  logic [31:0] push_rank_1, push_value_1, push_rank_2, push_value_2, out_value;
  logic [31:0] pop_value = '0;
  logic [FLOWS-1:0] push_flow_1, push_flow_2, out_flow;
  logic [FLOWS-1:0] pop_flow = '0;
  logic [CW-1:0] occupancy;

  int n_cmp = 0, n_bad = 0, cyc_n = 0;
  bit started = 0;
  el_t m_set[$], m_egr[$], env_set[$], m_inf_el, s_e1, s_e2;
  bit m_inf = 0, e_p1, e_p2, e_pop, e_deq, s_p1 = 0, s_p2 = 0, s_pop = 0;
  int m_rr = 0, g0, g1;
  logic [N-1:0] e_ready;
  logic [31:0] beats[$];
  int beat_cyc[$];

  always #5 clk = ~clk;

  pifo_push_pop_ctrl #(.N_REQ(N), .SIZE(SIZE), .FLOWS(FLOWS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rank(req_rank), .req_value(req_value), .req_flow(req_flow),
    .push_1(push_1), .push_rank_1(push_rank_1), .push_value_1(push_value_1), .push_flow_1(push_flow_1),
    .push_2(push_2), .push_rank_2(push_rank_2), .push_value_2(push_value_2), .push_flow_2(push_flow_2),
    .pop(pop), .pop_value(pop_value), .pop_flow(pop_flow), .pop_valid(pop_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_flow(out_flow),
    .occupancy(occupancy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int min_idx(input el_t q[$]);
    int b = 0;
    for (int i = 1; i < q.size(); i++) if (q[i].rank < q[b].rank) b = i;
    return b;
  endfunction

  // Expected outputs from the logical element set, egress queue and own round-robin pointer.
  always @(negedge clk) begin
    int j, free;
    if (started) begin
      g0 = -1;
      g1 = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (req_valid[j]) begin
          if (g0 < 0) g0 = j;
          else if (g1 < 0) g1 = j;
        end
      end
      free = SIZE - m_set.size();
      e_p1 = !rst && g0 >= 0 && free >= 1;
      e_p2 = e_p1 && g1 >= 0 && free >= 2;
      e_ready = '0;
      if (e_p1) e_ready[g0] = 1'b1;
      if (e_p2) e_ready[g1] = 1'b1;
      e_deq = m_egr.size() > 0 && out_ready;
      e_pop = !rst && m_set.size() > 0 && (m_egr.size() + int'(m_inf) - int'(e_deq)) < 2;
      chk("req_ready", req_ready, e_ready);
      chk("push_1", push_1, e_p1);
      chk("push_2", push_2, e_p2);
      chk("pop", pop, e_pop);
      chk("occupancy", occupancy, m_set.size());
      chk("out_valid", out_valid, m_egr.size() > 0);
      if (m_egr.size() > 0) begin
        chk("out_value", out_value, m_egr[0].value);
        chk("out_flow", out_flow, m_egr[0].flow);
      end
      if (e_p1) chk("push_rank_1", push_rank_1, req_rank[g0]);
      if (e_p2) chk("push_rank_2", push_rank_2, req_rank[g1]);
      if (out_valid && out_ready) begin
        beats.push_back(out_value);
        beat_cyc.push_back(cyc_n);
      end
    end
    s_p1 = push_1;
    s_p2 = push_2;
    s_pop = pop;
    s_e1 = '{push_rank_1, push_value_1, push_flow_1};
    s_e2 = '{push_rank_2, push_value_2, push_flow_2};
  end

  always @(posedge clk) begin
    int i;
    cyc_n++;
    if (rst) begin
      m_set.delete();
      m_egr.delete();
      m_inf = 0;
      m_rr = 0;
    end else if (started) begin
      if (e_deq) void'(m_egr.pop_front());
      if (m_inf) m_egr.push_back(m_inf_el);
      m_inf = e_pop;
      if (e_pop) begin
        i = min_idx(m_set);
        m_inf_el = m_set[i];
        m_set.delete(i);
      end
      if (e_p1) m_set.push_back('{req_rank[g0], req_value[g0], req_flow[g0]});
      if (e_p2) m_set.push_back('{req_rank[g1], req_value[g1], req_flow[g1]});
      if (e_p2) m_rr = (g1 + 1) % N;
      else if (e_p1) m_rr = (g0 + 1) % N;
    end
    started = 1;
  end

  // FlowScheduler stand-in: pop result one cycle after the request, pushes visible next cycle.
  always @(posedge clk) begin
    int i;
    if (rst) begin
      env_set.delete();
      pop_valid <= 1'b0;
    end else begin
      if (s_pop && env_set.size() > 0) begin
        i = min_idx(env_set);
        pop_valid <= 1'b1;
        pop_value <= env_set[i].value;
        pop_flow <= env_set[i].flow;
        env_set.delete(i);
      end else pop_valid <= 1'b0;
      if (s_p1) env_set.push_back(s_e1);
      if (s_p2) env_set.push_back(s_e2);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int r);
    req_rank[i] = 32'(r);
    req_value[i] = 32'(r + 1000);
    req_flow[i] = FLOWS'(r);
  endtask

  task automatic chk_beats(input string name, input int base, input int n);
    chk({name, "_count"}, beats.size(), n);
    for (int i = 0; i < n; i++) chk(name, i < beats.size() ? beats[i] : 'x, base + i);
  endtask

  initial begin
    int n2, pat[4];
    int exp1[6];
    pat = '{1, 0, 0, 1};
    exp1 = '{1001, 1002, 1010, 1020, 1030, 1040};
    cyc(2);
    rst = 1'b0;
    // park ranks 1,2 in the skid buffer so later pops stay blocked
    set_req(2, 1); set_req(3, 2); req_valid = 4'b1100;
    #1 chk("pre_ready", req_ready, 4'b1100);
    cyc(); req_valid = '0;
    cyc(6);
    set_req(0, 40); set_req(1, 30); set_req(2, 20); set_req(3, 10); req_valid = 4'b1111;
    #1 chk("t1_c0_ready", req_ready, 4'b0011); chk("t1_c0_occ", occupancy, 0);
    cyc(); req_valid = 4'b1100;
    #1 chk("t1_c1_ready", req_ready, 4'b1100); chk("t1_c1_occ", occupancy, 2);
    cyc(); req_valid = '0;
    #1 chk("t1_c2_occ", occupancy, 4); chk("t1_c2_pop", pop, 0);
    beats.delete(); out_ready = 1'b1;
    cyc(12); out_ready = 1'b0;
    chk("t1_count", beats.size(), 6);
    for (int i = 0; i < 6; i++) chk("t1_beat", i < beats.size() ? beats[i] : 'x, exp1[i]);
    n2 = 0;
    req_valid = 4'b0001;
    while (m_set.size() < 9 && n2 < 40) begin
      set_req(0, 100 + n2);
      n2++;
      cyc();
    end
    #1 chk("t2_occ9", occupancy, 9);
    set_req(0, 200); set_req(1, 201); req_valid = 4'b0011;
    #1 chk("t2_ready", req_ready, 4'b0010); chk("t2_push2", push_2, 0);
    cyc();
    #1 chk("t2_occ10", occupancy, 10); chk("t2_full_ready", req_ready, 4'b0000);
    cyc(); req_valid = '0; beats.delete(); out_ready = 1'b1;
    cyc(20); out_ready = 1'b0;
    chk("t2_count", beats.size(), n2 + 1);
    for (int i = 0; i <= n2; i++) chk("t2_beat", i < beats.size() ? beats[i] : 'x, (i < n2) ? 1100 + i : 1201);
    set_req(2, 5); req_valid = 4'b0100; out_ready = 1'b1;
    #1 chk("t3_ready", req_ready, 4'b0100); chk("t3_pop_t", pop, 0);
    cyc(); req_valid = '0;
    #1 chk("t3_pop_t1", pop, 1); chk("t3_ov_t1", out_valid, 0);
    cyc();
    #1 chk("t3_pv_t2", pop_valid, 1); chk("t3_pval_t2", pop_value, 1005); chk("t3_ov_t2", out_valid, 0);
    cyc();
    #1 chk("t3_ov_t3", out_valid, 1); chk("t3_oval_t3", out_value, 1005);
    cyc(2); out_ready = 1'b0;
    req_valid = 4'b0011;
    set_req(0, 66); set_req(1, 61); cyc();
    set_req(0, 64); set_req(1, 62); cyc();
    set_req(0, 65); set_req(1, 63); cyc();
    req_valid = '0;
    cyc(3); beats.delete(); beat_cyc.delete(); out_ready = 1'b1;
    cyc(10); out_ready = 1'b0;
    chk_beats("t4_beat", 1061, 6);
    for (int i = 1; i < 6; i++) chk("t4_back_to_back", i < beat_cyc.size() ? beat_cyc[i] - beat_cyc[0] : -1, i);
    req_valid = 4'b0011;
    set_req(0, 56); set_req(1, 51); cyc();
    set_req(0, 54); set_req(1, 52); cyc();
    set_req(0, 55); set_req(1, 53); cyc();
    req_valid = '0;
    cyc(3); beats.delete();
    for (int i = 0; i < 24; i++) begin
      out_ready = pat[i % 4][0];
      cyc();
    end
    out_ready = 1'b0;
    chk_beats("t5_beat", 1051, 6);
    req_valid = 4'b0011;
    set_req(0, 45); set_req(1, 41); cyc();
    set_req(0, 44); set_req(1, 42); cyc();
    req_valid = 4'b0001; set_req(0, 43); cyc();
    req_valid = '0;
    cyc(3); out_ready = 1'b1;
    #1 chk("t6_pop_before_rst", pop, 1);
    cyc(); out_ready = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    #1 chk("t6_ov_after_rst", out_valid, 0); chk("t6_occ_after_rst", occupancy, 0);
    beats.delete(); set_req(0, 7); req_valid = 4'b0001; out_ready = 1'b1;
    cyc(); req_valid = '0;
    cyc(6);
    chk_beats("t6_beat", 1007, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, %0d cycles", cyc_n);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
